// File: rtl/program_loader.sv
// program_loader: fills the CPU RAM from the ui_in pins while the CPU is in
// programming mode. Each accepted byte is pushed over the shared bus as
// MAR-address load, MAR-data load, then RAM write. The loader holds the
// control block for the whole session and flags completion on done_load.
module program_loader #(
    parameter int RAM_BYTES = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              programming,
    input  logic [7:0]        ui_data,
    input  logic              ui_valid,
    input  logic              ui_last,
    output logic              ready,
    output logic              done_load,
    output logic              cpu_hold,
    output logic [7:0]        bus_out,
    output logic              bus_oe,
    output logic              nLma,
    output logic              nLmd,
    output logic              nLr,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ADDR,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    // Highest RAM address; reaching it ends the session and stops addr from wrapping.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        byte_q,  byte_d;
    logic              last_q,  last_d;
    logic [ADDR_W:0]   count_q, count_d;

    // State and datapath registers; async reset drops everything to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            byte_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    // Next-state logic: session start, byte handshake, write bookkeeping, abort.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        last_d  = last_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (programming) begin
                    state_d = S_WAIT;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            S_WAIT: begin
                // Abort wins over a simultaneous handshake: nothing is captured.
                if (!programming) begin
                    state_d = S_IDLE;
                end else if (ui_valid) begin
                    byte_d  = ui_data;
                    last_d  = ui_last;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = programming ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                state_d = programming ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                // The nLr pulse of this cycle always lands, so the byte is
                // counted even when the session is being aborted.
                count_d = count_q + CNT_ONE;
                if (addr_q != LAST_ADDR) begin
                    addr_d = addr_q + ADDR_ONE;
                end
                if (!programming) begin
                    state_d = S_IDLE;
                end else if (last_q || (addr_q == LAST_ADDR)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                // Only a drop of programming re-arms; a held level never restarts.
                if (!programming) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode of the registered state.
    always_comb begin
        ready     = 1'b0;
        done_load = 1'b0;
        cpu_hold  = (state_q != S_IDLE);
        bus_out   = 8'h00;
        bus_oe    = 1'b0;
        nLma      = 1'b1;
        nLmd      = 1'b1;
        nLr       = 1'b1;
        case (state_q)
            S_WAIT: begin
                ready = 1'b1;
            end
            S_ADDR: begin
                bus_oe  = 1'b1;
                bus_out = 8'(addr_q);
                nLma    = 1'b0;
            end
            S_DATA: begin
                bus_oe  = 1'b1;
                bus_out = byte_q;
                nLmd    = 1'b0;
            end
            S_WRITE: begin
                nLr = 1'b0;
            end
            S_DONE: begin
                done_load = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a bus/RAM model captures MAR loads and
// RAM writes; the main sequence walks full load, re-arm, early end, abort and
// asynchronous reset with hand-computed expectations.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       programming;
    logic [7:0] ui_data;
    logic       ui_valid;
    logic       ui_last;
    logic       ready;
    logic       done_load;
    logic       cpu_hold;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       nLma;
    logic       nLmd;
    logic       nLr;
    logic [4:0] byte_count;

    int errs   = 0;
    int checks = 0;

    program_loader #(.RAM_BYTES(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .programming (programming),
        .ui_data     (ui_data),
        .ui_valid    (ui_valid),
        .ui_last     (ui_last),
        .ready       (ready),
        .done_load   (done_load),
        .cpu_hold    (cpu_hold),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .nLma        (nLma),
        .nLmd        (nLmd),
        .nLr         (nLr),
        .byte_count  (byte_count)
    );

    always #5 clk = ~clk;

    // Bus-side model: MAR address/data latches and the 16-byte RAM.
    logic [3:0] mar_a   = 4'h0;
    logic [7:0] mar_d   = 8'h00;
    logic [3:0] last_wa = 4'h0;
    logic [7:0] ram [16];
    int         nlr_cnt  = 0;
    int         done_cnt = 0;

    always @(posedge clk) begin
        if (!nLma) mar_a <= bus_out[3:0];
        if (!nLmd) mar_d <= bus_out;
        if (!nLr) begin
            ram[mar_a] <= mar_d;
            last_wa    <= mar_a;
            nlr_cnt    <= nlr_cnt + 1;
        end
        if (done_load) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte, wait (bounded) for ready, return at the negedge after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic l);
        ui_data  = d;
        ui_valid = 1'b1;
        ui_last  = l;
        for (int t = 0; t < 20 && !ready; t++) @(negedge clk);
        chk("send_ready", ready, 1);
        @(negedge clk);
        ui_valid = 1'b0;
        ui_last  = 1'b0;
    endtask

    task automatic wait_done();
        for (int t = 0; t < 20 && !done_load; t++) @(negedge clk);
        chk("wait_done", done_load, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int d0;
        rst         = 1'b0;
        programming = 1'b0;
        ui_data     = 8'h00;
        ui_valid    = 1'b0;
        ui_last     = 1'b0;
        #1 rst = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_done", done_load, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_oe", bus_oe, 0);
        chk("rst_bus", bus_out, 0);
        chk("rst_strobes", {nLma, nLmd, nLr}, 3'b111);
        chk("rst_count", byte_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", cpu_hold, 0);
        chk("idle_ready", ready, 0);

        // Full load with ui_valid held high: 1,0,0,0 ready pattern, 16 writes
        programming = 1'b1;
        ui_valid    = 1'b1;
        ui_data     = 8'h10;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            chk("fl_ready", ready, (c % 4 == 0));
            chk("fl_hold", cpu_hold, 1);
            case (c % 4)
                1: begin
                    chk("fl_nlma", nLma, 0);
                    chk("fl_addr", bus_out, c / 4);
                    ui_data = 8'(8'h11 + c / 4);
                end
                2: begin
                    chk("fl_nlmd", nLmd, 0);
                    chk("fl_data", bus_out, 8'h10 + c / 4);
                end
                3: begin
                    chk("fl_nlr", nLr, 0);
                    chk("fl_oe", bus_oe, 0);
                end
                default: begin
                end
            endcase
        end
        @(negedge clk);
        chk("fl_done", done_load, 1);
        chk("fl_count", byte_count, 16);
        chk("fl_nlr_cnt", nlr_cnt, 16);
        for (int i = 0; i < 16; i++) chk("fl_ram", ram[i], 8'h10 + i);

        // Re-arm: programming held high in DONE starts nothing
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("ra_done", done_load, 1);
            chk("ra_ready", ready, 0);
        end
        chk("ra_nlr_cnt", nlr_cnt, 16);
        programming = 1'b0;
        ui_valid    = 1'b0;
        @(negedge clk);
        chk("ra_done_fall", done_load, 0);
        chk("ra_hold_fall", cpu_hold, 0);

        // Early end: second session starts cleared, three bytes, last flag
        programming = 1'b1;
        @(negedge clk);
        chk("ee_ready", ready, 1);
        chk("ee_count0", byte_count, 0);
        n0 = nlr_cnt;
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hFF, 1'b1);
        wait_done();
        chk("ee_count", byte_count, 3);
        chk("ee_nlr_cnt", nlr_cnt - n0, 3);
        chk("ee_ram0", ram[0], 8'hA5);
        chk("ee_ram1", ram[1], 8'h5A);
        chk("ee_ram2", ram[2], 8'hFF);
        for (int i = 3; i < 16; i++) chk("ee_ram_keep", ram[i], 8'h10 + i);
        programming = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Abort during DATA of byte 5
        d0 = done_cnt;
        programming = 1'b1;
        @(negedge clk);
        n0 = nlr_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 1'b0);
        send_byte(8'h65, 1'b0);
        @(negedge clk);
        chk("ab_in_data", nLmd, 0);
        programming = 1'b0;
        @(negedge clk);
        chk("ab_hold", cpu_hold, 0);
        chk("ab_nlr", nLr, 0 + 1);
        chk("ab_ready", ready, 0);
        chk("ab_count", byte_count, 5);
        repeat (3) @(negedge clk);
        chk("ab_count_hold", byte_count, 5);
        chk("ab_nlr_cnt", nlr_cnt - n0, 5);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_ram4", ram[4], 8'h64);
        chk("ab_ram5", ram[5], 8'h15);

        // Asynchronous reset during ADDR, then restart from address 0
        programming = 1'b1;
        @(negedge clk);
        send_byte(8'h77, 1'b0);
        chk("ar_in_addr", nLma, 0);
        #2 rst = 1'b1;
        #1;
        chk("ar_nlma", nLma, 1);
        chk("ar_oe", bus_oe, 0);
        chk("ar_bus", bus_out, 0);
        chk("ar_hold", cpu_hold, 0);
        chk("ar_ready", ready, 0);
        chk("ar_strobes", {nLmd, nLr}, 2'b11);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ar_restart_ready", ready, 1);
        chk("ar_restart_count", byte_count, 0);
        send_byte(8'h33, 1'b1);
        chk("ar_restart_addr", bus_out, 0);
        wait_done();
        chk("ar_last_wa", last_wa, 0);
        chk("ar_ram0", ram[0], 8'h33);
        chk("ar_count", byte_count, 1);
        programming = 1'b0;
        @(negedge clk);
        chk("end_idle", cpu_hold, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
